// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, fill level,
// sticky overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTHBIT = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [DEPTHBIT:0]   level,
  output logic                overflow,
  output logic                underflow
);

  localparam int                  MAXCOUNT = 1 << DEPTHBIT;
  localparam logic [DEPTHBIT:0]   MAX_LVL  = MAXCOUNT[DEPTHBIT:0];
  localparam logic [DEPTHBIT:0]   AF_LVL   = AF_LEVEL[DEPTHBIT:0];
  localparam logic [DEPTHBIT:0]   AE_LVL   = AE_LEVEL[DEPTHBIT:0];
  localparam logic [DEPTHBIT:0]   LVL_ONE  = 1;
  localparam logic [DEPTHBIT-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]    mem_q [MAXCOUNT];
  logic [DEPTHBIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTHBIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTHBIT:0]   level_q, level_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_acc, rd_acc;

  // Status flags decode the registered level directly, so they carry no extra latency.
  assign empty        = (level_q == '0);
  assign full         = (level_q == MAX_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign rd_data  = (FWFT != 0) ? mem_q[rd_ptr_q] : rd_data_q;
  assign rd_valid = (FWFT != 0) ? ~empty : rd_valid_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (clr) begin
      // Flush wins over any concurrent request; memory contents are left stale.
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      rd_data_d = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      if (wr_en & full)  ovf_d = 1'b1;
      if (rd_en & empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
